// File: rtl/rsa_engine_sched_pkg.sv
// Shared types for the RSA engine scheduler: FSM state encoding and
// configuration register select codes.
package rsa_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_KICK,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] CFG_N = 2'd0;
    localparam logic [1:0] CFG_E = 2'd1;
    localparam logic [1:0] CFG_D = 2'd2;

endpackage

// File: rtl/rsa_engine_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that was not served last wins.
module rsa_rr_arb2 (
    input  logic enc_valid_i,
    input  logic dec_valid_i,
    input  logic last_dec_i,
    output logic grant_enc_o,
    output logic grant_dec_o
);

    always_comb begin
        grant_enc_o = enc_valid_i && (!dec_valid_i || last_dec_i);
        grant_dec_o = dec_valid_i && (!enc_valid_i || !last_dec_i);
    end

endmodule

// File: rtl/rsa_engine_sched.sv
// Shares one RSA modexp engine between encrypt and decrypt requesters,
// replays the engine start protocol, and guards it with a watchdog.
module rsa_engine_sched
    import rsa_sched_pkg::*;
#(
    parameter int unsigned WIDTH          = 128,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_valid,
    output logic             enc_ready,
    input  logic [WIDTH-1:0] enc_msg,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [WIDTH-1:0] dec_msg,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [WIDTH-1:0] cfg_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_is_dec,
    output logic             rsp_timeout,
    output logic             busy,
    output logic             eng_reset,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_message,
    output logic [WIDTH-1:0] eng_key,
    output logic [WIDTH-1:0] eng_n,
    input  logic [WIDTH-1:0] eng_c,
    input  logic             eng_done
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic             last_dec_q;
    logic [WIDTH-1:0] n_q, e_q, d_q;
    logic [WIDTH-1:0] msg_q, key_q, eng_n_q, rsp_data_q;
    logic             is_dec_q, rsp_to_q, rsp_valid_q, start_q;
    logic [CNT_W-1:0] wd_q;
    logic             grant_enc, grant_dec, idle;

    rsa_rr_arb2 u_arb (
        .enc_valid_i (enc_valid),
        .dec_valid_i (dec_valid),
        .last_dec_i  (last_dec_q),
        .grant_enc_o (grant_enc),
        .grant_dec_o (grant_dec)
    );

    assign idle        = (state_q == ST_IDLE);
    assign enc_ready   = idle && grant_enc;
    assign dec_ready   = idle && grant_dec;
    assign busy        = !idle;
    // Engine is held in reset whenever the scheduler is, not only in PRIME.
    assign eng_reset   = reset || (state_q == ST_PRIME);
    assign eng_start   = start_q;
    assign eng_message = msg_q;
    assign eng_key     = key_q;
    assign eng_n       = eng_n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_is_dec  = is_dec_q;
    assign rsp_timeout = rsp_to_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_dec_q  <= 1'b1;
            n_q         <= '0;
            e_q         <= '0;
            d_q         <= '0;
            msg_q       <= '0;
            key_q       <= '0;
            eng_n_q     <= '0;
            rsp_data_q  <= '0;
            is_dec_q    <= 1'b0;
            rsp_to_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            start_q     <= 1'b0;
            wd_q        <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_sel)
                    CFG_N:   n_q <= cfg_data;
                    CFG_E:   e_q <= cfg_data;
                    CFG_D:   d_q <= cfg_data;
                    default: ;
                endcase
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_enc || grant_dec) begin
                        msg_q    <= grant_dec ? dec_msg : enc_msg;
                        key_q    <= grant_dec ? d_q : e_q;
                        eng_n_q  <= n_q;
                        is_dec_q <= grant_dec;
                        start_q  <= 1'b1;
                        state_q  <= ST_PRIME;
                    end
                end
                ST_PRIME: state_q <= ST_KICK;
                ST_KICK: begin
                    start_q <= 1'b0;
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done seen in the final watchdog cycle still wins.
                    if (eng_done) begin
                        rsp_data_q  <= eng_c;
                        rsp_to_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (wd_q == WD_LAST) begin
                        rsp_data_q  <= '0;
                        rsp_to_q    <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        last_dec_q  <= is_dec_q;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_engine_sched.sv
// Bench for rsa_engine_sched: behavioural engine, timeline-based reference
// model checked every cycle, plus directed scenarios with literal results.
module tb_rsa_engine_sched;

    localparam int W    = 32;
    localparam int TO   = 64;
    localparam int NLAT = 50;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enc_valid = 1'b0, dec_valid = 1'b0;
    logic          enc_ready, dec_ready;
    logic [W-1:0]  enc_msg = '0, dec_msg = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = '0;
    logic [W-1:0]  cfg_data = '0;
    logic          rsp_valid, rsp_is_dec, rsp_timeout;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_data;
    logic          busy, eng_reset, eng_start;
    logic [W-1:0]  eng_message, eng_key, eng_n;
    logic [W-1:0]  eng_c = '0;
    logic          eng_done = 1'b0;

    always #5 clk = ~clk;

    rsa_engine_sched #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enc_valid   (enc_valid),
        .enc_ready   (enc_ready),
        .enc_msg     (enc_msg),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_msg     (dec_msg),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_is_dec  (rsp_is_dec),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .eng_reset   (eng_reset),
        .eng_start   (eng_start),
        .eng_message (eng_message),
        .eng_key     (eng_key),
        .eng_n       (eng_n),
        .eng_c       (eng_c),
        .eng_done    (eng_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [63:0] r, x;
        if (m == 0) return '0;
        r = 64'd1 % m;
        x = b % m;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r[W-1:0];
    endfunction

    // Engine model: done rises NLAT cycles after start drops, cleared by reset.
    bit eng_hang = 1'b0;
    bit e_run = 1'b0;
    int e_cnt = 0;
    always @(posedge clk) begin
        if (eng_reset) begin
            e_run <= 1'b0; e_cnt <= 0; eng_done <= 1'b0;
        end else if (eng_start) begin
            e_run <= 1'b1; e_cnt <= 0; eng_done <= 1'b0;
            eng_c <= modexp(eng_message, eng_key, eng_n);
        end else if (e_run && !eng_hang) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt + 1 >= NLAT) eng_done <= 1'b1;
        end
    end

    // Reference model: position of the current op on its timeline since accept.
    bit           m_busy, m_resp, m_rdec, m_rto, m_last_dec;
    int           m_t;
    logic [W-1:0] m_cfg [4];
    logic [W-1:0] m_msg, m_key, m_n, m_rdata;

    always @(negedge clk) begin
        bit ge, gd;
        if (reset) begin
            chk("eng_reset_during_reset", eng_reset, 1);
            m_busy = 0; m_resp = 0; m_rdec = 0; m_rto = 0; m_last_dec = 1; m_t = 0;
            for (int i = 0; i < 4; i++) m_cfg[i] = '0;
            m_msg = '0; m_key = '0; m_n = '0; m_rdata = '0;
        end else begin
            ge = !m_busy && enc_valid && (!dec_valid || m_last_dec);
            gd = !m_busy && dec_valid && (!enc_valid || !m_last_dec);
            chk("busy", busy, m_busy);
            chk("enc_ready", enc_ready, ge);
            chk("dec_ready", dec_ready, gd);
            chk("rsp_valid", rsp_valid, m_resp);
            chk("eng_start", eng_start, m_busy && !m_resp && (m_t == 1 || m_t == 2));
            chk("eng_reset", eng_reset, m_busy && !m_resp && m_t == 1);
            chk("eng_message", eng_message, m_msg);
            chk("eng_key", eng_key, m_key);
            chk("eng_n", eng_n, m_n);
            if (m_resp) begin
                chk("rsp_data", rsp_data, m_rdata);
                chk("rsp_is_dec", rsp_is_dec, m_rdec);
                chk("rsp_timeout", rsp_timeout, m_rto);
            end

            if (!m_busy) begin
                if (ge || gd) begin
                    m_busy = 1; m_t = 1; m_rdec = gd;
                    m_msg = ge ? enc_msg : dec_msg;
                    m_key = ge ? m_cfg[1] : m_cfg[2];
                    m_n   = m_cfg[0];
                end
            end else if (m_resp) begin
                if (rsp_ready) begin
                    m_busy = 0; m_resp = 0; m_last_dec = m_rdec;
                end
            end else begin
                if (m_t >= 3) begin
                    if (eng_done) begin
                        m_resp = 1; m_rdata = eng_c; m_rto = 0;
                    end else if (m_t - 3 == TO - 1) begin
                        m_resp = 1; m_rdata = '0; m_rto = 1;
                    end
                end
                m_t++;
            end
            if (cfg_we && cfg_sel != 2'd3) m_cfg[cfg_sel] = cfg_data;
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input logic [W-1:0] d);
        cfg_we = 1; cfg_sel = sel; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        repeat (n) @(posedge clk);
        #1 reset = 0;
    endtask

    // Returns one cycle after the accept edge (posedge + 1).
    task automatic wait_accept(input bit dec, output int acc);
        bit got = 0;
        acc = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (dec ? (dec_valid && dec_ready) : (enc_valid && enc_ready)) begin
                acc = cyc; got = 1;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_wait: no accept within budget, required an accept");
        end
        @(posedge clk); #1;
    endtask

    // Returns at the negedge of the first cycle with rsp_valid high.
    task automatic wait_resp(output int rc);
        bit got = 0;
        rc = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin rc = cyc; got = 1; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_wait: no response within budget, required a response");
        end
    endtask

    task automatic run_op(input bit dec, input logic [W-1:0] msg, output int lat,
                          output logic [W-1:0] data, output bit isd, output bit to);
        int acc, rc;
        if (dec) begin dec_valid = 1; dec_msg = msg; end
        else begin enc_valid = 1; enc_msg = msg; end
        wait_accept(dec, acc);
        enc_valid = 0; dec_valid = 0;
        wait_resp(rc);
        lat = rc - acc; data = rsp_data; isd = rsp_is_dec; to = rsp_timeout;
        @(posedge clk); #1;
    endtask

    task automatic configure();
        cfg_write(2'd0, 32'd2773);
        cfg_write(2'd1, 32'd17);
        cfg_write(2'd2, 32'd157);
        cfg_write(2'd3, 32'd999);
    endtask

    initial begin
        int acc, rc, lat, nrv;
        logic [W-1:0] data;
        bit isd, to;
        int order [8];
        int k;

        do_reset(3);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_eng_n", eng_n, 0);
        chk("reset_eng_reset", eng_reset, 0);
        @(posedge clk); #1;
        configure();

        // Encrypt 920 with explicit PRIME/KICK observation.
        enc_valid = 1; enc_msg = 32'd920;
        wait_accept(0, acc);
        enc_valid = 0;
        @(negedge clk);
        chk("prime_start", eng_start, 1);
        chk("prime_reset", eng_reset, 1);
        chk("prime_msg", eng_message, 920);
        chk("prime_key", eng_key, 17);
        chk("prime_n", eng_n, 2773);
        @(negedge clk);
        chk("kick_start", eng_start, 1);
        chk("kick_reset", eng_reset, 0);
        wait_resp(rc);
        chk("enc_latency", rc - acc, 54);
        chk("enc_data", rsp_data, 948);
        chk("enc_is_dec", rsp_is_dec, 0);
        @(posedge clk); #1;

        run_op(1, 32'd948, lat, data, isd, to);
        chk("dec_latency", lat, 54);
        chk("dec_data", data, 920);
        chk("dec_is_dec", isd, 1);

        // Both requesters valid from reset: strict alternation starting with enc.
        do_reset(2);
        configure();
        enc_msg = 32'd100; dec_msg = 32'd200;
        enc_valid = 1; dec_valid = 1;
        k = 0;
        for (int i = 0; i < 1200 && k < 8; i++) begin
            @(negedge clk);
            if (enc_valid && enc_ready) begin order[k] = 0; k++; end
            else if (dec_valid && dec_ready) begin order[k] = 1; k++; end
            else continue;
            @(posedge clk); #1;
            enc_msg = enc_msg + 1; dec_msg = dec_msg + 1;
            if (k == 8) begin enc_valid = 0; dec_valid = 0; end
        end
        chk("rr_accept_count", k, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_order_%0d", i), order[i], i % 2);
        wait_resp(rc);
        @(posedge clk); #1;

        // Hung engine: watchdog response, then normal recovery.
        eng_hang = 1;
        run_op(0, 32'd5, lat, data, isd, to);
        chk("to_latency", lat, 67);
        chk("to_flag", to, 1);
        chk("to_data", data, 0);
        eng_hang = 0;
        run_op(1, 32'd948, lat, data, isd, to);
        chk("post_to_latency", lat, 54);
        chk("post_to_flag", to, 0);
        chk("post_to_data", data, 920);

        // Backpressured response with a mid-op modulus write and a pending request.
        rsp_ready = 0;
        enc_valid = 1; enc_msg = 32'd920;
        wait_accept(0, acc);
        enc_msg = 32'd65;
        repeat (8) @(posedge clk);
        #1 cfg_write(2'd0, 32'd3233);
        wait_resp(rc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_enc_ready", enc_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 948);
            chk("bp_eng_n", eng_n, 2773);
        end
        @(posedge clk); #1 rsp_ready = 1;
        wait_accept(0, acc);
        enc_valid = 0;
        @(negedge clk);
        chk("next_op_n", eng_n, 3233);
        chk("next_op_msg", eng_message, 65);
        wait_resp(rc);
        chk("next_op_data", rsp_data, 2790);
        @(posedge clk); #1;

        // Reset during WAIT drops the operation.
        enc_valid = 1; enc_msg = 32'd920;
        wait_accept(0, acc);
        enc_valid = 0;
        repeat (5) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("abort_eng_reset", eng_reset, 1);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_eng_start", eng_start, 0);
        nrv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) nrv++;
        end
        chk("abort_no_response", nrv, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_engine_sched.md
# rsa_engine_sched

Scheduler that shares one RSA modular-exponentiation engine (`top_level_enc`-style: clk/reset/start/message/e_key/n → c/done) between an encrypt requester and a decrypt requester. It holds the modulus and both keys in configuration registers and arbitrates round-robin between the two requesters. For each operation it replays the engine's required start protocol and returns the result through a valid/ready response port. A watchdog aborts a hung engine.

## Interface
- `WIDTH`, 128, operand/key/modulus width
- `TIMEOUT_CYCLES`, 100000, max cycles in WAIT before abort (≥2)
- `CNT_W`, 17, watchdog counter width (≥ clog2(TIMEOUT_CYCLES))

- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `enc_valid` in 1, `enc_ready` out 1, `enc_msg` in WIDTH: encrypt request
- `dec_valid` in 1, `dec_ready` out 1, `dec_msg` in WIDTH: decrypt request
- `cfg_we` in 1, `cfg_sel` in 2, `cfg_data` in WIDTH: config write (sel 0=n, 1=e_key, 2=d_key, 3=ignored)
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out WIDTH, `rsp_is_dec` out 1, `rsp_timeout` out 1: response
- `busy` out 1: state ≠ IDLE
- `eng_reset` out 1, `eng_start` out 1, `eng_message`/`eng_key`/`eng_n` out WIDTH: engine drive
- `eng_c` in WIDTH, `eng_done` in 1: engine result

## Operation
- States: IDLE → PRIME → KICK → WAIT → RESP → IDLE.
- IDLE: grant = the sole valid requester. If both are valid, grant goes to the one not served last. `last_dec` resets to 1, so encrypt wins the first tie.
  - The granted `*_ready` = 1 combinationally; other ready = 0. Ready may depend on valid.
  - Accept (valid&&ready): latch msg into `eng_message`, key (e for enc, d for dec) into `eng_key`, `n` into `eng_n`, and the requester id. Go to PRIME.
- PRIME (1 cycle): `eng_reset`=1, `eng_start`=1.
- KICK (1 cycle): `eng_reset`=0, `eng_start`=1.
- WAIT: `eng_start`=0; watchdog counts from 0.
  - `eng_done`=1: capture `eng_c` into `rsp_data`, `rsp_timeout`=0, go to RESP.
  - Otherwise, when count = TIMEOUT_CYCLES−1: `rsp_data`=0, `rsp_timeout`=1, go to RESP.
  - If `eng_done` and timeout coincide, done wins.
- `eng_done` is ignored outside WAIT (stale level from the previous op).
- RESP: `rsp_valid`=1. `rsp_data`/`rsp_is_dec`/`rsp_timeout` are held stable until `rsp_ready`. Handshake → IDLE; `last_dec` updated.
- Config writes take effect the next cycle, in any state. Engine operands are latched only at accept, so mid-op writes never change `eng_*`.
- `eng_reset` = `reset` | (state==PRIME), so the engine stays in reset whenever the scheduler is.

## Timing
- Reset values: state IDLE, `enc_ready`/`dec_ready`/`rsp_valid`/`rsp_is_dec`/`rsp_timeout`/`eng_start`/`busy` = 0, `rsp_data`/`eng_message`/`eng_key`/`eng_n`/config regs = 0, `eng_reset` = 1 during reset, `last_dec` = 1.
- Reset mid-operation: the next cycle is IDLE with all reset values. Any in-flight result is dropped; no response is issued.
- Cycle timeline, with accept at cycle 0:
  - PRIME at 1, KICK at 2, WAIT from 3.
  - `eng_done` sampled in cycle k ≥ 3 → `rsp_valid` at k+1.
  - Timeout → `rsp_valid` at cycle 3+TIMEOUT_CYCLES.
- RESP handshake in cycle r → IDLE at r+1. The earliest next accept is r+1.
- At most one operation is in flight. No request is accepted outside IDLE.

## Structure
- Package `rsa_sched_pkg`: state enum, cfg_sel codes (`CFG_N`, `CFG_E`, `CFG_D`).
- Sub-module `rsa_rr_arb2`: 2-way round-robin grant from valid pair plus `last_dec`. Watchdog and FSM stay inline.

## Test plan
Bench uses a behavioral engine model: done level N cycles after its start, cleared by `eng_reset`.
- Config n=2773, e=17, d=157; enc 920; model gives c=948 after N=50 → PRIME/KICK pulses seen with msg 920/key 17/n 2773; `rsp_data`=948, `rsp_is_dec`=0, `rsp_valid` at cycle 54.
- dec 948 → `eng_key`=157; `rsp_data`=920, `rsp_is_dec`=1.
- Both valid from reset, `rsp_ready`=1, four requests each → grant order enc, dec, enc, dec…; no starvation.
- TIMEOUT_CYCLES=64, model never finishes → `rsp_valid` at cycle 67 with `rsp_timeout`=1, `rsp_data`=0; next request proceeds normally.
- Hold `rsp_ready`=0 for 10 cycles with `enc_valid`=1, and write n=3233 during WAIT → response stable, `enc_ready`=0 throughout, `eng_n` stays 2773; the next op uses 3233.
- Assert `reset` during WAIT → next cycle `busy`=0, `rsp_valid`=0, `eng_reset`=1; no response for the aborted op.
